pong_score: RTL
===============

# pong_score

Two-player score keeper and match sequencer for the Pong display path. Consumes one-cycle point strobes from the ball/collision logic. Maintains two 2-digit BCD scores and drives them on `dig0`–`dig3` in the digit order the text renderer expects. Also sequences the match through idle, play, post-point hold and game-over states, and exposes status flags for the game controller and text overlay.

## Interface
Parameters:
- `WIN_SCORE`, default 11: score that ends the match. Legal range 1..99.
- `HOLD_CYCLES`, default 25_000_000: length of the post-point hold, in clock cycles. Legal range ≥1, width ≤32 bits.

Ports:
- `clk`, input, 1: system clock. The block uses this single clock only.
- `reset_n`, input, 1: reset, asynchronous and active-low.
- `start`, input, 1: one-cycle strobe. Clears both scores and begins play.
- `p1_point`, input, 1: one-cycle strobe. Player 1 scored.
- `p2_point`, input, 1: one-cycle strobe. Player 2 scored.
- `dig0`, output, 4: player 1 ones digit, BCD.
- `dig1`, output, 4: player 1 tens digit, BCD.
- `dig2`, output, 4: player 2 ones digit, BCD.
- `dig3`, output, 4: player 2 tens digit, BCD.
- `playing`, output, 1: high when the state is PLAY.
- `hold`, output, 1: high when the state is HOLD.
- `game_over`, output, 1: high when the state is OVER.
- `winner`, output, 2: 01 = player 1, 10 = player 2, 11 = tie, 00 = no result yet.

## Operation
States are IDLE, PLAY, HOLD and OVER.

Reset:
- State goes to IDLE.
- All digits go to 0.
- `winner` = 00.
- `playing`, `hold` and `game_over` are all low.

`start` has priority over point strobes in every state:
- Both scores clear to 00.
- `winner` clears to 00.
- Hold counter clears.
- Next state is PLAY.

IDLE:
- Point strobes are ignored.
- The state is left only on `start`.

PLAY:
- When either or both point strobes are high, the matching scores increment by 1 in the same update.
- If a new score equals `WIN_SCORE`, the next state is OVER:
  - only player 1 reached it: `winner` = 01;
  - only player 2 reached it: `winner` = 10;
  - both reached it in the same cycle: `winner` = 11.
- Otherwise the next state is HOLD and the hold counter loads `HOLD_CYCLES-1`.

HOLD:
- Point strobes are ignored; this debounces repeated ball-out strobes.
- The counter decrements each cycle.
- When the counter is 0, the next state is PLAY.

OVER:
- Point strobes are ignored.
- Scores and `winner` are frozen until `start`.

BCD arithmetic, per player:
- Ones digit 0..8 increments by 1.
- Ones digit 9 wraps to 0 and the tens digit increments.
- At 99 the score saturates (unreachable when `WIN_SCORE` ≤ 99, but required).
- The win compare uses constants derived at elaboration: `WIN_SCORE/10` and `WIN_SCORE%10`.
- The compare is made against the incremented (next) value, not the registered value.

Outputs:
- All outputs are registered.
- Status flags are decoded from the state register.

## Timing
- A point strobe in PLAY sampled at edge N:
  - the new digits are visible after edge N;
  - `hold` (or `game_over`) goes high after edge N.
- `hold` stays high for exactly `HOLD_CYCLES` cycles; `playing` returns on the following cycle.
- The earliest next accepted point is sampled at edge N+`HOLD_CYCLES`+1.
- `start` sampled at edge N: scores are 00 and `playing` = 1 after edge N. This applies in any state, including mid-HOLD.
- Asserting `reset_n` low forces the reset values immediately, regardless of clock, including mid-HOLD or mid-increment.
- Deasserting `reset_n` takes effect on the next rising `clk`. Integration synchronises the deassertion externally.
- Strobes longer than one cycle are not supported:
  - a strobe held high through PLAY scores again only after the hold expires;
  - with `HOLD_CYCLES` ≥ 1 it can never score twice on consecutive edges.

## Structure
- Package `pong_pkg` holds:
  - the state enum `score_state_t` (IDLE, PLAY, HOLD, OVER);
  - typedef `bcd_digit_t` (4-bit);
  - the `winner` encodings `WIN_NONE`/`WIN_P1`/`WIN_P2`/`WIN_TIE`.
- Sub-module `bcd2_counter`, instantiated once per player:
  - two BCD digits;
  - inputs `inc` and `clr`; `clr` has priority;
  - saturates at 99;
  - exposes its combinational next value for the win compare;
  - same `clk`/`reset_n`.
- The top level holds the FSM, the hold counter (width `$clog2(HOLD_CYCLES)`, minimum 1) and the winner register.

## Test plan
Unless a line states otherwise, the bench uses `HOLD_CYCLES`=3 and `WIN_SCORE`=11.

- **Reset/idle:** release reset, then pulse `p1_point`.
  - Digits stay 0000, `winner`=00, and only IDLE (no status flag) is seen.
  - Then `start`: `playing`=1 after one edge.
- **Carry and hold:** after `start`, give 10 `p1_point` strobes, each spaced 4 cycles.
  - Expect `dig1`/`dig0`=1/0 and `dig3`/`dig2`=0/0.
  - Each strobe gives `hold` high for exactly 3 cycles.
  - A strobe issued during `hold` produces no change.
- **Win:** continue with one more accepted `p1_point`, reaching 11.
  - `game_over`=1 and `winner`=01 after one edge; `hold` stays low.
  - Further strobes leave 11–00 frozen.
- **Tie:** bring both players to 10, then pulse `p1_point` and `p2_point` in the same cycle.
  - Both scores become 11, `winner`=11, `game_over`=1.
- **Start priority and mid-hold restart:** during HOLD at score 05–03, pulse `start` and `p2_point` together.
  - Scores become 00–00, `playing`=1, and no point is credited.
- **Async reset mid-game:** pull `reset_n` low between clock edges at score 07–04 in HOLD.
  - Outputs reach the reset values before the next edge.
  - IDLE persists after release.

Source files
------------

// File: rtl/pong_score_pkg.sv
// Purpose : shared types and constants for the Pong score keeper.
// Latency : n/a (types, constants and one elaboration-time helper only).
// Backpr. : n/a.
//
// Contents:
//   score_state_t : match sequencer states (IDLE, PLAY, HOLD, OVER)
//   bcd_digit_t   : one packed BCD digit
//   WIN_*         : encodings driven on the winner output
//   bcd_pair      : splits a binary 0..99 into {tens, ones} BCD digits
package pong_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    HOLD = 2'd2,
    OVER = 2'd3
  } score_state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_TIE  = 2'b11;

  // Used only on elaboration constants (the win target), never on live data.
  function automatic logic [7:0] bcd_pair(input int unsigned value);
    bcd_digit_t tens;
    bcd_digit_t ones;
    tens = 4'((value / 10) % 10);
    ones = 4'(value % 10);
    return {tens, ones};
  endfunction

endpackage

// File: rtl/pong_score_bcd2_counter.sv
// Purpose : two-digit BCD up-counter (00..99, saturating) for one player.
// Latency : registered digits update on the edge after inc/clr; the next
//           value is also exported combinationally for look-ahead compares.
// Backpr. : none; inc is a plain strobe and is honoured every cycle.
//
// Ports:
//   clk, reset_n      : clock, asynchronous active-low reset
//   inc               : add one to the score this cycle
//   clr               : clear the score to 00 (wins over inc)
//   ones_o, tens_o    : registered BCD digits
//   ones_nxt_o,
//   tens_nxt_o        : value the digits will take after the next edge
module bcd2_counter
  import pong_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] ones_o,
  output logic [3:0] tens_o,
  output logic [3:0] ones_nxt_o,
  output logic [3:0] tens_nxt_o
);

  localparam bcd_digit_t BCD_ZERO = 4'd0;
  localparam bcd_digit_t BCD_NINE = 4'd9;

  bcd_digit_t ones_q, ones_d;
  bcd_digit_t tens_q, tens_d;

  always_comb begin
    ones_d = ones_q;
    tens_d = tens_q;
    if (clr) begin
      ones_d = BCD_ZERO;
      tens_d = BCD_ZERO;
    end else if (inc) begin
      if (ones_q == BCD_NINE) begin
        // 99 holds: the score display never rolls back over to 00.
        if (tens_q != BCD_NINE) begin
          ones_d = BCD_ZERO;
          tens_d = tens_q + 4'd1;
        end
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ones_q <= BCD_ZERO;
      tens_q <= BCD_ZERO;
    end else begin
      ones_q <= ones_d;
      tens_q <= tens_d;
    end
  end

  assign ones_o     = ones_q;
  assign tens_o     = tens_q;
  assign ones_nxt_o = ones_d;
  assign tens_nxt_o = tens_d;

endmodule

// File: rtl/pong_score.sv
// Purpose : two-player Pong score keeper and match sequencer.
// Latency : one edge from a start/point strobe to updated digits and flags.
// Backpr. : none; strobes outside PLAY (or during the post-point hold) are
//           dropped, start is always accepted.
//
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   start                 : clear scores and begin play (beats point strobes)
//   p1_point, p2_point    : one-cycle point strobes from the collision logic
//   dig0 / dig1           : player 1 ones / tens digit (BCD)
//   dig2 / dig3           : player 2 ones / tens digit (BCD)
//   playing, hold,
//   game_over             : state decodes (PLAY, HOLD, OVER)
//   winner                : 01 p1, 10 p2, 11 tie, 00 undecided
module pong_score
  import pong_pkg::*;
#(
  parameter int WIN_SCORE   = 11,
  parameter int HOLD_CYCLES = 25_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       p1_point,
  input  logic       p2_point,
  output logic [3:0] dig0,
  output logic [3:0] dig1,
  output logic [3:0] dig2,
  output logic [3:0] dig3,
  output logic       playing,
  output logic       hold,
  output logic       game_over,
  output logic [1:0] winner
);

  // A one-cycle hold needs a counter that only ever holds 0, so keep at
  // least one bit rather than letting $clog2 collapse the width to zero.
  localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HCW-1:0] HOLD_LOAD = HCW'(HOLD_CYCLES - 1);

  localparam logic [7:0] WIN_BCD = bcd_pair(WIN_SCORE);
  localparam bcd_digit_t WIN_T   = WIN_BCD[7:4];
  localparam bcd_digit_t WIN_O   = WIN_BCD[3:0];

  score_state_t   state_q, state_d;
  logic [HCW-1:0] cnt_q, cnt_d;
  logic [1:0]     win_q, win_d;

  logic       p1_inc, p2_inc;
  logic       p1_hit, p2_hit;
  logic [3:0] p1_ones, p1_tens, p1_ones_nxt, p1_tens_nxt;
  logic [3:0] p2_ones, p2_tens, p2_ones_nxt, p2_tens_nxt;

  // Points only count in PLAY, and a simultaneous start swallows them so
  // a restart never begins with a stray point on the board.
  assign p1_inc = !start && (state_q == PLAY) && p1_point;
  assign p2_inc = !start && (state_q == PLAY) && p2_point;

  // Compare the post-increment value so the winning point moves straight
  // to OVER instead of passing through an extra HOLD first.
  assign p1_hit = p1_inc && (p1_tens_nxt == WIN_T) && (p1_ones_nxt == WIN_O);
  assign p2_hit = p2_inc && (p2_tens_nxt == WIN_T) && (p2_ones_nxt == WIN_O);

  bcd2_counter u_p1_score (
    .clk        (clk),
    .reset_n    (reset_n),
    .inc        (p1_inc),
    .clr        (start),
    .ones_o     (p1_ones),
    .tens_o     (p1_tens),
    .ones_nxt_o (p1_ones_nxt),
    .tens_nxt_o (p1_tens_nxt)
  );

  bcd2_counter u_p2_score (
    .clk        (clk),
    .reset_n    (reset_n),
    .inc        (p2_inc),
    .clr        (start),
    .ones_o     (p2_ones),
    .tens_o     (p2_tens),
    .ones_nxt_o (p2_ones_nxt),
    .tens_nxt_o (p2_tens_nxt)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    if (start) begin
      state_d = PLAY;
      cnt_d   = '0;
      win_d   = WIN_NONE;
    end else begin
      unique case (state_q)
        PLAY: begin
          if (p1_inc || p2_inc) begin
            if (p1_hit && p2_hit) begin
              state_d = OVER;
              win_d   = WIN_TIE;
            end else if (p1_hit) begin
              state_d = OVER;
              win_d   = WIN_P1;
            end else if (p2_hit) begin
              state_d = OVER;
              win_d   = WIN_P2;
            end else begin
              state_d = HOLD;
              cnt_d   = HOLD_LOAD;
            end
          end
        end
        // Loaded with HOLD_CYCLES-1 and left on the zero count, so the
        // hold flag is up for exactly HOLD_CYCLES cycles.
        HOLD: begin
          if (cnt_q == '0) begin
            state_d = PLAY;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        IDLE: ;
        OVER: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      win_q   <= WIN_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
    end
  end

  assign dig0      = p1_ones;
  assign dig1      = p1_tens;
  assign dig2      = p2_ones;
  assign dig3      = p2_tens;
  assign playing   = (state_q == PLAY);
  assign hold      = (state_q == HOLD);
  assign game_over = (state_q == OVER);
  assign winner    = win_q;

endmodule
